data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Data-side memory slave that answers the processor's MEM-stage load/store requests.
//  Decodes byte address + MemLen into byte lanes, performs clocked stores, returns
//  combinational load data (sign/zero extended) within the same cycle as the request.
//  Traps misaligned and out-of-range accesses in a sticky fault register. Sits beside
//  the processor in the top level, wired port-to-port to its MEM_* data interface.
// PARAMETERS
//  WIDTH        32            data/address width (only 32 supported)
//  DEPTH_WORDS  1024          number of 32-bit words in the array (power of 2)
//  ADDR_BASE    32'h0000_0000 byte address of word 0; must be DEPTH_WORDS*4 aligned
// PORTS
//  CLK           in   1      clock, all state updates on rising edge
//  RST           in   1      asynchronous reset, active-high
//  MEM_alu_out   in   32     byte address of the access
//  MEM_mem_in    in   32     store data, right-aligned (byte in [7:0], half in [15:0])
//  MEM_MemLen    in   3      access size/sign: RISC-V funct3 encoding
//  MEM_MemRead   in   1      load request this cycle
//  MEM_MemWrite  in   1      store request this cycle
//  MEM_mem_out   out  32     load data, combinational, extended per MemLen
//  fault         out  1      sticky fault flag
//  fault_addr    out  32     address of first faulting access since last clear
//  fault_cause   out  2      01 misaligned, 10 out of range, 11 both
//  fault_clr     in   1      synchronous clear of fault/fault_addr/fault_cause
//  rd_count      out  32     completed loads (see CONFIGURATION)
//  wr_count      out  32     completed stores (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: fault=0, fault_addr=0, fault_cause=0, rd_count=0, wr_count=0. Array contents
//    are NOT reset. MEM_mem_out is combinational; it is 0 whenever MemRead=0.
//  - MemLen: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned,
//    101 half unsigned. Stores use 000/001/010; 100/101 on a store behave as 000/001.
//    011/110/111 are illegal: treated as misaligned (cause bit0).
//  - Word index = (addr-ADDR_BASE)>>2; lane = addr[1:0]. Little-endian byte order.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Out of range: addr outside
//    [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
//  - Legal store: on the CLK edge only the selected byte enables are written; the other
//    bytes of the word are preserved. Faulting store: no array write at all.
//  - Legal load: data available same cycle (zero-latency read), lane-shifted then
//    extended. Faulting load: MEM_mem_out=0.
//  - MemRead and MemWrite both high: store performed at the edge; load returns pre-write
//    contents (read-before-write). Both counters increment.
//  - Fault capture: on a faulting access when fault=0, set fault and latch fault_addr and
//    fault_cause on the edge. Later faults while fault=1 do not overwrite.
//  - fault_clr with a new fault in the same cycle: the new fault is captured (set wins).
//  - RST asserted mid-store: array write for that edge is not guaranteed; all status regs
//    go to reset values immediately.
// CONFIGURATION
//  DMEM_PERF_CNT_EN defined: rd_count/wr_count increment by 1 per legal (non-faulting)
//    load/store on the edge; wrap 0xFFFF_FFFF -> 0; cleared only by RST.
//  DMEM_PERF_CNT_EN undefined: counters not built; rd_count and wr_count tied to 0.
// TESTING
//  1. RST pulse mid-run -> fault=0, fault_addr=0, counters=0 asynchronously, before next edge.
//  2. SW 0xDEADBEEF @0x10; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF.
//  3. SW 0x11223344 @0x20; SB 0xAA @0x21; LW @0x20 -> 0x1122AA44; SH 0x5566 @0x22 -> LW 0x5566AA44.
//  4. LW @0x22 -> mem_out=0, fault=1, cause=01, fault_addr=0x22; then SW @0x4000
//     (DEPTH 1024) -> no write, fault_addr stays 0x22; fault_clr -> all zero.
//  5. Read+write same cycle @0x30 (old 0x1, new 0x2) -> mem_out=0x1 that cycle, LW next cycle 0x2.
//  6. With DMEM_PERF_CNT_EN: 3 legal LW + 2 legal SW + 1 faulting LW -> rd_count=3, wr_count=2;
//     preload rd_count 0xFFFFFFFF via force, one LW -> 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-side memory slave: zero-latency loads, byte-enabled clocked stores, sticky fault capture.
// Optional DMEM_PERF_CNT_EN builds the load/store completion counters; otherwise they read 0.
module data_memory_responder #(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] MEM_alu_out,
    input  logic [WIDTH-1:0] MEM_mem_in,
    input  logic [2:0]       MEM_MemLen,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    output logic [WIDTH-1:0] MEM_mem_out,
    output logic             fault,
    output logic [WIDTH-1:0] fault_addr,
    output logic [1:0]       fault_cause,
    input  logic             fault_clr,
    output logic [31:0]      rd_count,
    output logic [31:0]      wr_count
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [WIDTH-1:0] offset;
    logic [AW-1:0]    word_idx;
    logic [1:0]       lane;
    logic             is_byte, is_half, is_word, len_bad;
    logic             misal, oor, flt, ld_ok, st_ok;

    // Base is DEPTH*4 aligned, so addresses below it wrap to a large offset and land out of range.
    assign offset   = MEM_alu_out - ADDR_BASE;
    assign word_idx = offset[AW+1:2];
    assign lane     = offset[1:0];
    assign is_byte  = (MEM_MemLen[1:0] == 2'b00);
    assign is_half  = (MEM_MemLen[1:0] == 2'b01);
    assign is_word  = (MEM_MemLen == 3'b010);
    assign len_bad  = !(is_byte || is_half || is_word);
    assign misal    = len_bad || (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign oor      = |offset[WIDTH-1:AW+2];
    assign flt      = (MEM_MemRead || MEM_MemWrite) && (misal || oor);
    assign ld_ok    = MEM_MemRead && !flt;
    assign st_ok    = MEM_MemWrite && !flt;

    logic [WIDTH-1:0] rd_word, rd_shift;
    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        MEM_mem_out = '0;
        if (ld_ok) begin
            if (is_byte)
                MEM_mem_out = MEM_MemLen[2] ? {24'h0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            else if (is_half)
                MEM_mem_out = MEM_MemLen[2] ? {16'h0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            else
                MEM_mem_out = rd_word;
        end
    end

    logic [3:0]       be;
    logic [WIDTH-1:0] wdata;
    assign be    = is_word ? 4'hF : (is_half ? (4'b0011 << lane) : (4'b0001 << lane));
    assign wdata = is_word ? MEM_mem_in
                 : (is_half ? {2{MEM_mem_in[15:0]}} : {4{MEM_mem_in[7:0]}});

    // Array is deliberately left without reset.
    always_ff @(posedge CLK) begin
        if (st_ok) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    logic             fault_q, fault_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;
    logic [1:0]       fcause_q, fcause_d;

    // A new fault wins over a simultaneous clear.
    always_comb begin
        fault_d  = fault_q;
        faddr_d  = faddr_q;
        fcause_d = fcause_q;
        if (flt && (!fault_q || fault_clr)) begin
            fault_d  = 1'b1;
            faddr_d  = MEM_alu_out;
            fcause_d = {oor, misal};
        end else if (fault_clr) begin
            fault_d  = 1'b0;
            faddr_d  = '0;
            fcause_d = 2'b00;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fault_q  <= 1'b0;
            faddr_q  <= '0;
            fcause_q <= 2'b00;
        end else begin
            fault_q  <= fault_d;
            faddr_q  <= faddr_d;
            fcause_q <= fcause_d;
        end
    end

    assign fault       = fault_q;
    assign fault_addr  = faddr_q;
    assign fault_cause = fcause_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    assign rd_cnt_d = rd_cnt_q + {31'h0, ld_ok};
    assign wr_cnt_d = wr_cnt_q + {31'h0, st_ok};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized check of data_memory_responder against a byte-array reference model.
module tb_data_memory_responder;
    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] MEM_alu_out = '0, MEM_mem_in = '0;
    logic [2:0]  MEM_MemLen = '0;
    logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0, fault_clr = 1'b0;
    logic [31:0] MEM_mem_out, fault_addr, rd_count, wr_count;
    logic        fault;
    logic [1:0]  fault_cause;

    data_memory_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0)) dut (
        .CLK(CLK), .RST(RST), .MEM_alu_out(MEM_alu_out), .MEM_mem_in(MEM_mem_in),
        .MEM_MemLen(MEM_MemLen), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_mem_out(MEM_mem_out), .fault(fault), .fault_addr(fault_addr),
        .fault_cause(fault_cause), .fault_clr(fault_clr),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    int vecs = 0, errs = 0;

    logic [7:0]  mm [4*DEPTH];
    bit          m_f = 1'b0;
    logic [31:0] m_fa = '0, m_rdc = '0, m_wrc = '0;
    logic [1:0]  m_fc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_status();
        chk("fault", {31'h0, fault}, {31'h0, m_f});
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_cause", {30'h0, fault_cause}, {30'h0, m_fc});
        chk("rd_count", rd_count, m_rdc);
        chk("wr_count", wr_count, m_wrc);
    endtask

    task automatic idle();
        @(negedge CLK);
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; fault_clr = 1'b0;
    endtask

    // One access cycle: check comb load data before the edge, then model the edge and check status.
    task automatic acc(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] len,
                       input logic [31:0] d, input bit clr, output logic [31:0] got);
        int n, base;
        bit bad, mis, oor, flt;
        logic [31:0] exp;
        n    = (len[1:0] == 2'd0) ? 1 : ((len[1:0] == 2'd1) ? 2 : 4);
        bad  = (len == 3'd3) || (len == 3'd6) || (len == 3'd7);
        mis  = bad || ((a % 32'(n)) != 0);
        oor  = (a >= 32'(4*DEPTH));
        flt  = (rd || wr) && (mis || oor);
        base = int'(a[11:0]);
        exp  = '0;
        if (rd && !flt) begin
            for (int i = 0; i < n; i++) exp[8*i +: 8] = mm[base+i];
            if (!len[2] && n == 1 && exp[7])  exp[31:8]  = '1;
            if (!len[2] && n == 2 && exp[15]) exp[31:16] = '1;
        end
        @(negedge CLK);
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_alu_out = a; MEM_MemLen = len;
        MEM_mem_in = d; fault_clr = clr;
        #1;
        got = MEM_mem_out;
        chk("mem_out", MEM_mem_out, exp);
        @(posedge CLK);
        if (wr && !flt)
            for (int i = 0; i < n; i++) mm[base+i] = d[8*i +: 8];
`ifdef DMEM_PERF_CNT_EN
        if (rd && !flt) m_rdc++;
        if (wr && !flt) m_wrc++;
`endif
        if (flt && (!m_f || clr)) begin
            m_f = 1'b1; m_fa = a; m_fc = {oor, mis};
        end else if (clr) begin
            m_f = 1'b0; m_fa = '0; m_fc = '0;
        end
        #1;
        chk_status();
    endtask

    logic [31:0] g;
    logic [31:0] ra, rdat;
    logic [2:0]  rl;

    initial begin
        #12;
        chk_status();
        @(negedge CLK); RST = 1'b0;

        for (int w = 0; w < DEPTH; w++) acc(0, 1, 32'(4*w), 3'b010, 32'h0, 0, g);

        acc(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0, g);
        acc(1, 0, 32'h13, 3'b000, 0, 0, g); chk("lb13", g, 32'hFFFFFFDE);
        acc(1, 0, 32'h13, 3'b100, 0, 0, g); chk("lbu13", g, 32'h000000DE);
        acc(1, 0, 32'h10, 3'b001, 0, 0, g); chk("lh10", g, 32'hFFFFBEEF);
        acc(1, 0, 32'h12, 3'b101, 0, 0, g); chk("lhu12", g, 32'h0000DEAD);

        acc(0, 1, 32'h20, 3'b010, 32'h11223344, 0, g);
        acc(0, 1, 32'h21, 3'b000, 32'h000000AA, 0, g);
        acc(1, 0, 32'h20, 3'b010, 0, 0, g); chk("lw20a", g, 32'h1122AA44);
        acc(0, 1, 32'h22, 3'b001, 32'h00005566, 0, g);
        acc(1, 0, 32'h20, 3'b010, 0, 0, g); chk("lw20b", g, 32'h5566AA44);

        acc(1, 0, 32'h22, 3'b010, 0, 0, g); chk("lw22_out", g, 32'h0);
        chk("flt_addr22", fault_addr, 32'h22);
        chk("flt_cause22", {30'h0, fault_cause}, 32'h1);
        acc(0, 1, 32'h4000, 3'b010, 32'hCAFEF00D, 0, g);
        chk("flt_sticky", fault_addr, 32'h22);
        acc(1, 0, 32'h0, 3'b010, 0, 0, g); chk("no_wrap_wr", g, 32'h0);
        acc(0, 0, 32'h0, 3'b000, 0, 1, g);
        chk("clr_fault", {31'h0, fault}, 32'h0);

        acc(1, 0, 32'h1001, 3'b011, 0, 0, g);
        acc(1, 0, 32'h5000, 3'b010, 0, 1, g);
        chk("setwins_addr", fault_addr, 32'h5000);
        chk("setwins_cause", {30'h0, fault_cause}, 32'h2);
        acc(0, 0, 32'h0, 3'b000, 0, 1, g);

        acc(0, 1, 32'h30, 3'b010, 32'h1, 0, g);
        acc(1, 1, 32'h30, 3'b010, 32'h2, 0, g); chk("rbw_old", g, 32'h1);
        acc(1, 0, 32'h30, 3'b010, 0, 0, g); chk("rbw_new", g, 32'h2);

        for (int k = 0; k < 2000; k++) begin
            case ($urandom % 8)
                0:       ra = $urandom;
                1:       ra = 32'(4*DEPTH) + $urandom_range(0, 15);
                2:       ra = 32'(4*DEPTH) - $urandom_range(1, 4);
                default: ra = $urandom_range(0, 127);
            endcase
            rl   = 3'($urandom % 8);
            rdat = $urandom;
            acc(bit'($urandom % 2), bit'($urandom % 2), ra, rl, rdat, ($urandom % 6) == 0, g);
        end

        acc(1, 0, 32'h7, 3'b010, 0, 0, g);
        idle();
        #2 RST = 1'b1;
        #1;
        m_f = 1'b0; m_fa = '0; m_fc = '0; m_rdc = '0; m_wrc = '0;
        chk("async_rst_fault", {31'h0, fault}, 32'h0);
        chk("async_rst_addr", fault_addr, 32'h0);
        chk("async_rst_rdc", rd_count, 32'h0);
        @(negedge CLK); RST = 1'b0;

        for (int i = 0; i < 3; i++) acc(1, 0, 32'(8*i), 3'b010, 0, 0, g);
        for (int i = 0; i < 2; i++) acc(0, 1, 32'h40 + 32'(4*i), 3'b010, $urandom, 0, g);
        acc(1, 0, 32'h42, 3'b010, 0, 0, g);
`ifdef DMEM_PERF_CNT_EN
        chk("rdc3", rd_count, 32'd3);
        chk("wrc2", wr_count, 32'd2);
        idle();
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt_q;
        m_rdc = 32'hFFFF_FFFF;
        acc(1, 0, 32'h0, 3'b010, 0, 0, g);
        chk("rdc_wrap", rd_count, 32'h0);
`else
        chk("rdc_off", rd_count, 32'h0);
        chk("wrc_off", wr_count, 32'h0);
`endif
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
